// File: rtl/vc_input_buffer_if.sv
// Write/read request and status bundle for the multi-VC input buffer.
// master = link receiver / allocator side, slave = the buffer itself.
interface vc_input_buffer_if #(
    parameter int NUM_BITS = 8,
    parameter int DEPTH    = 8,
    parameter int NUM_VC   = 2
) ();
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int VW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

    logic                         wr_en;
    logic [VW-1:0]                wr_vc;
    logic [NUM_BITS-1:0]          fifo_in;
    logic                         rd_en;
    logic [VW-1:0]                rd_vc;
    logic [NUM_BITS-1:0]          fifo_out;
    logic                         rd_valid;
    logic [NUM_VC-1:0]            empty;
    logic [NUM_VC-1:0]            full;
    logic [NUM_VC-1:0][CW-1:0]    fifo_counter;
    logic [NUM_VC-1:0]            credit_out;
    logic                         wr_err;
    logic                         rd_err;

    modport master (
        output wr_en, wr_vc, fifo_in, rd_en, rd_vc,
        input  fifo_out, rd_valid, empty, full, fifo_counter, credit_out, wr_err, rd_err
    );

    modport slave (
        input  wr_en, wr_vc, fifo_in, rd_en, rd_vc,
        output fifo_out, rd_valid, empty, full, fifo_counter, credit_out, wr_err, rd_err
    );
endinterface

// File: rtl/vc_input_buffer.sv
// NUM_VC independent circular FIFOs sharing one write and one read port.
// Define VC_BUF_CREDIT_EN to generate per-VC credit pulses on each pop.

module vc_buf_lane #(
    parameter int NUM_BITS = 8,
    parameter int DEPTH    = 8,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_acc,
    input  logic                rd_acc,
    input  logic [NUM_BITS-1:0] din,
    output logic [NUM_BITS-1:0] head,
    output logic [CW-1:0]       count
);
    logic [NUM_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];
endmodule

module vc_input_buffer #(
    parameter int NUM_BITS = 8,
    parameter int DEPTH    = 8,
    parameter int NUM_VC   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    vc_input_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int VW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

    logic [NUM_VC-1:0]                wr_sel;
    logic [NUM_VC-1:0]                rd_sel;
    logic [NUM_VC-1:0][NUM_BITS-1:0]  head;
    logic [NUM_VC-1:0][CW-1:0]        cnt;
    logic [NUM_VC-1:0]                empty;
    logic [NUM_VC-1:0]                full;
    logic [NUM_BITS-1:0]              rd_data;
    logic [NUM_BITS-1:0]              out_q;
    logic                             rd_valid_q;
    logic                             wr_err_q;
    logic                             rd_err_q;

    // One-hot accept vectors; an out-of-range VC matches no lane and is rejected.
    always_comb begin
        wr_sel  = '0;
        rd_sel  = '0;
        rd_data = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            wr_sel[v] = bus.wr_en && (bus.wr_vc == VW'(v)) && !full[v];
            rd_sel[v] = bus.rd_en && (bus.rd_vc == VW'(v)) && !empty[v];
            if (rd_sel[v]) rd_data = head[v];
        end
    end

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        vc_buf_lane #(.NUM_BITS(NUM_BITS), .DEPTH(DEPTH)) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .wr_acc (wr_sel[v]),
            .rd_acc (rd_sel[v]),
            .din    (bus.fifo_in),
            .head   (head[v]),
            .count  (cnt[v])
        );
        assign empty[v] = (cnt[v] == '0);
        assign full[v]  = (cnt[v] == CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= '0;
            rd_valid_q <= 1'b0;
            wr_err_q   <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            if (|rd_sel) out_q <= rd_data;
            rd_valid_q <= |rd_sel;
            wr_err_q   <= bus.wr_en && !(|wr_sel);
            rd_err_q   <= bus.rd_en && !(|rd_sel);
        end
    end

`ifdef VC_BUF_CREDIT_EN
    logic [NUM_VC-1:0] credit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) credit_q <= '0;
        else        credit_q <= rd_sel;
    end

    assign bus.credit_out = credit_q;
`else
    assign bus.credit_out = '0;
`endif

    assign bus.fifo_out     = out_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.wr_err       = wr_err_q;
    assign bus.rd_err       = rd_err_q;
    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.fifo_counter = cnt;
endmodule

// File: tb/tb_vc_input_buffer.sv
// Randomised + directed bench for vc_input_buffer: per-VC queue model,
// expected read data scoreboarded and checked by an independent monitor.
module tb_vc_input_buffer;
    localparam int NB = 8;
    localparam int D  = 8;
    localparam int NV = 2;
    localparam int CW = 4;
    localparam int VW = 1;

    typedef struct packed {
        logic                  rvld;
        logic                  werr;
        logic                  rerr;
        logic [NV-1:0]         credit;
        logic [NV-1:0][CW-1:0] cnt;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    vc_input_buffer_if #(.NUM_BITS(NB), .DEPTH(D), .NUM_VC(NV)) bus ();

    vc_input_buffer #(.NUM_BITS(NB), .DEPTH(D), .NUM_VC(NV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t         pend = '0;
    exp_t         cur  = '0;
    logic [NB-1:0] mdl [NV][$];
    logic [NB-1:0] exp_q [$];
    logic [NB-1:0] last_out = '0;
    int           n_chk  = 0;
    int           n_pass = 0;
    bit           mon_en = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // One clock of stimulus; the model decides acceptance from pre-edge occupancy.
    task automatic drive(bit we, int wvc, logic [NB-1:0] wd, bit re, int rvc);
        bit wacc, racc;
        @(posedge clk);
        #1;
        bus.wr_en   = we;
        bus.wr_vc   = VW'(wvc);
        bus.fifo_in = wd;
        bus.rd_en   = re;
        bus.rd_vc   = VW'(rvc);
        wacc = we && (wvc < NV) && (mdl[wvc].size() < D);
        racc = re && (rvc < NV) && (mdl[rvc].size() > 0);
        pend.rvld   = racc;
        pend.werr   = we && !wacc;
        pend.rerr   = re && !racc;
        pend.credit = '0;
        if (racc) begin
            exp_q.push_back(mdl[rvc].pop_front());
`ifdef VC_BUF_CREDIT_EN
            pend.credit[rvc] = 1'b1;
`endif
        end
        if (wacc) mdl[wvc].push_back(wd);
        for (int v = 0; v < NV; v++) pend.cnt[v] = CW'(mdl[v].size());
    endtask

    task automatic idle();
        drive(1'b0, 0, '0, 1'b0, 0);
    endtask

    task automatic check_reset_values(string tag);
        chk({tag, "_empty"},   bus.empty, {NV{1'b1}});
        chk({tag, "_full"},    bus.full, '0);
        chk({tag, "_count"},   bus.fifo_counter, '0);
        chk({tag, "_out"},     bus.fifo_out, '0);
        chk({tag, "_rvalid"},  bus.rd_valid, '0);
        chk({tag, "_credit"},  bus.credit_out, '0);
        chk({tag, "_errs"},    {bus.wr_err, bus.rd_err}, '0);
    endtask

    task automatic async_reset(string tag);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        rst_n = 1'b0;
        pend  = '0;
        for (int v = 0; v < NV; v++) mdl[v].delete();
        exp_q.delete();
        last_out = '0;
        #1;
        check_reset_values(tag);
    endtask

    always @(posedge clk) cur = pend;

    // Monitor: pops the scoreboard whenever the DUT presents read data.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("rd_valid", bus.rd_valid, cur.rvld);
            if (bus.rd_valid && exp_q.size() > 0) last_out = exp_q.pop_front();
            chk("fifo_out", bus.fifo_out, last_out);
            chk("wr_err", bus.wr_err, cur.werr);
            chk("rd_err", bus.rd_err, cur.rerr);
            chk("credit_out", bus.credit_out, cur.credit);
            chk("fifo_counter", bus.fifo_counter, cur.cnt);
            for (int v = 0; v < NV; v++) begin
                chk("empty", bus.empty[v], cur.cnt[v] == 0);
                chk("full", bus.full[v], cur.cnt[v] == CW'(D));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_en = 1'b0; bus.wr_vc = '0; bus.fifo_in = '0;
        bus.rd_en = 1'b0; bus.rd_vc = '0;
        #1;
        async_reset("reset");
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) idle();
        check_reset_values("idle");

        // Fill VC1, overflow once, drain in order
        for (int i = 0; i < 8; i++) drive(1'b1, 1, NB'(8'h10 + i), 1'b0, 0);
        drive(1'b1, 1, 8'h55, 1'b0, 0);
        chk("full_vc1_only", bus.full, 2'b10);
        for (int i = 0; i < 8; i++) drive(1'b0, 0, '0, 1'b1, 1);
        idle();

        // Interleaved VCs
        drive(1'b1, 0, 8'hA0, 1'b0, 0);
        drive(1'b1, 1, 8'hB0, 1'b0, 0);
        drive(1'b1, 0, 8'hA1, 1'b0, 0);
        drive(1'b0, 0, '0, 1'b1, 1);
        drive(1'b0, 0, '0, 1'b1, 0);
        drive(1'b0, 0, '0, 1'b1, 0);
        idle();
        chk("interleave_counts", bus.fifo_counter, '0);

        // Full VC0 with simultaneous write+read, then empty VC0 with both
        for (int i = 0; i < 8; i++) drive(1'b1, 0, NB'(8'h30 + i), 1'b0, 0);
        drive(1'b1, 0, 8'h99, 1'b1, 0);
        idle();
        chk("full_wr_rd_count", bus.fifo_counter[0], 7);
        for (int i = 0; i < 7; i++) drive(1'b0, 0, '0, 1'b1, 0);
        drive(1'b1, 0, 8'h77, 1'b1, 0);
        idle();
        chk("empty_wr_rd_count", bus.fifo_counter[0], 1);
        drive(1'b0, 0, '0, 1'b1, 0);
        idle();

        // Pointer wrap with steady occupancy of 3
        for (int i = 0; i < 3; i++) drive(1'b1, 0, NB'(8'hC0 + i), 1'b0, 0);
        for (int i = 0; i < 20; i++) drive(1'b1, 0, NB'(8'hD0 + i), 1'b1, 0);
        idle();
        chk("wrap_count", bus.fifo_counter[0], 3);
        for (int i = 0; i < 3; i++) drive(1'b0, 0, '0, 1'b1, 0);
        idle();

        // Reset mid-burst at count 5
        for (int i = 0; i < 5; i++) drive(1'b1, 0, NB'(8'hE0 + i), 1'b0, 0);
        drive(1'b1, 0, 8'hEE, 1'b1, 0);
        @(negedge clk);
        #1;
        async_reset("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 0, 8'hA5, 1'b0, 0);
        drive(1'b0, 0, '0, 1'b1, 0);
        repeat (2) idle();

        // Randomised traffic in phases biased toward filling then draining
        for (int i = 0; i < 600; i++) begin
            int wp;
            wp = (i < 200) ? 3 : (i < 400) ? 1 : 2;
            drive(($urandom_range(0, 3) < wp), int'($urandom_range(0, NV - 1)), NB'($urandom),
                  ($urandom_range(0, 3) >= wp) || ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, NV - 1)));
        end
        repeat (3) idle();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
